// File: rtl/bpsk_rx_pkg.sv
// Shared types and sizing helpers for the BPSK receive chain.
// Used by bpsk_symbol_demod and symbol_integrator.
package bpsk_rx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEMOD    = 2'd1,
    DRAIN    = 2'd2,
    WAIT_LOW = 2'd3
  } state_t;

  // Room for WAVELENGTH terms of magnitude up to 2^DATA_WIDTH, plus sign.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned wl);
    return dw + 1 + $clog2(wl);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned sample_cnt_width(input int unsigned wl);
    return cnt_width(wl);
  endfunction

  function automatic int unsigned bit_cnt_width(input int unsigned pb);
    return cnt_width(pb);
  endfunction

  localparam int unsigned SAMPLE_CNT_W = sample_cnt_width(8);
  localparam int unsigned BIT_CNT_W    = bit_cnt_width(32);

endpackage

// File: rtl/bpsk_symbol_demod_if.sv
// Demodulated-bit valid/ready stream between bpsk_symbol_demod and its consumer.
interface bpsk_symbol_demod_if;
  logic bit_out;
  logic bit_valid;
  logic bit_ready;

  modport master (output bit_out, output bit_valid, input bit_ready);
  modport slave  (input bit_out, input bit_valid, output bit_ready);
endinterface

// File: rtl/bpsk_symbol_demod_symbol_integrator.sv
// Per-symbol correlator: centers each sample, applies the sign-only carrier
// reference, integrates over one symbol and slices the result to a bit.
module symbol_integrator
  import bpsk_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WAVELENGTH = 8,
  parameter int unsigned AMPLITUDE  = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_active,
  input  logic [DATA_WIDTH-1:0] i_sample,
  output logic                  o_decision,
  output logic                  o_decision_strobe
);

  localparam int unsigned ACC_W = acc_width(DATA_WIDTH, WAVELENGTH);
  localparam int unsigned SCW   = sample_cnt_width(WAVELENGTH);
  localparam logic [SCW-1:0] HALF    = SCW'(WAVELENGTH / 2);
  localparam logic [SCW-1:0] LAST    = SCW'(WAVELENGTH - 1);
  localparam logic [SCW-1:0] CNT_ONE = SCW'(1);
  localparam logic signed [DATA_WIDTH:0] AMP = (DATA_WIDTH + 1)'(AMPLITUDE);

  logic signed [DATA_WIDTH:0] w_centered;
  logic signed [ACC_W-1:0]    w_centered_ext;
  logic signed [ACC_W-1:0]    w_term;
  logic signed [ACC_W-1:0]    w_sum;
  logic                       w_last;

  logic signed [ACC_W-1:0]    r_acc;
  logic [SCW-1:0]             r_sample_cnt;

  assign w_centered     = $signed({1'b0, i_sample}) - AMP;
  assign w_centered_ext = {{(ACC_W - DATA_WIDTH - 1){w_centered[DATA_WIDTH]}}, w_centered};
  assign w_term         = (r_sample_cnt < HALF) ? w_centered_ext : -w_centered_ext;
  assign w_sum          = r_acc + w_term;
  assign w_last         = (r_sample_cnt == LAST);

  // Non-negative sum slices to 1, so an exact zero correlation yields 1.
  assign o_decision        = ~w_sum[ACC_W-1];
  assign o_decision_strobe = i_active & w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= '0;
      r_sample_cnt <= '0;
    end else if (i_active) begin
      if (w_last) begin
        r_acc        <= '0;
        r_sample_cnt <= '0;
      end else begin
        r_acc        <= w_sum;
        r_sample_cnt <= r_sample_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/bpsk_symbol_demod.sv
// BPSK symbol demodulator: frame FSM, single-entry output register and
// optional differential decoder (enabled by `define BPSK_DIFF_DECODE_EN).
module bpsk_symbol_demod
  import bpsk_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned WAVELENGTH   = 8,
  parameter int unsigned AMPLITUDE    = 127,
  parameter int unsigned PAYLOAD_BITS = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] signal,
  input  logic                  sync,
  bpsk_symbol_demod_if.master   bit_if,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int unsigned BCW = bit_cnt_width(PAYLOAD_BITS);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(PAYLOAD_BITS - 1);
  localparam logic [BCW-1:0] BIT_ONE  = BCW'(1);

  state_t r_state;
  state_t w_next;

  logic           r_sync_q;
  logic [BCW-1:0] r_bit_cnt;
  logic           r_bit;
  logic           r_valid;
  logic           r_overflow;
  logic           r_frame_done;

  logic w_start;
  logic w_active;
  logic w_frame_start;
  logic w_accept;
  logic w_last_accept;
  logic w_decision;
  logic w_strobe;
  logic w_bit;

  assign w_start       = sync & ~r_sync_q;
  assign w_frame_start = (r_state == IDLE) & w_start;
  // The start cycle already carries sample 0, so the integrator runs then too.
  assign w_active      = (r_state == DEMOD) | w_frame_start;
  assign w_accept      = r_valid & bit_if.bit_ready;

  symbol_integrator #(
    .DATA_WIDTH (DATA_WIDTH),
    .WAVELENGTH (WAVELENGTH),
    .AMPLITUDE  (AMPLITUDE)
  ) u_integrator (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_active          (w_active),
    .i_sample          (signal),
    .o_decision        (w_decision),
    .o_decision_strobe (w_strobe)
  );

`ifdef BPSK_DIFF_DECODE_EN
  logic r_prev_decision;

  // Tracks every decision, including ones dropped on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_decision <= 1'b1;
    end else if (w_frame_start) begin
      r_prev_decision <= 1'b1;
    end else if (w_strobe) begin
      r_prev_decision <= w_decision;
    end
  end

  assign w_bit = w_decision ^ r_prev_decision;
`else
  assign w_bit = w_decision;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sync_q  <= 1'b0;
      r_bit_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_sync_q <= sync;
      if (w_frame_start) begin
        r_bit_cnt <= '0;
      end else if (w_strobe) begin
        r_bit_cnt <= r_bit_cnt + BIT_ONE;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    w_last_accept = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next = DEMOD;
        end
      end
      DEMOD: begin
        if (w_strobe && (r_bit_cnt == LAST_BIT)) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_accept) begin
          w_next        = WAIT_LOW;
          w_last_accept = 1'b1;
        end
      end
      WAIT_LOW: begin
        if (!sync) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // A decision that collides with a full, unaccepted register is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit        <= 1'b0;
      r_valid      <= 1'b0;
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_accept;
      if (w_strobe) begin
        if (r_valid && !bit_if.bit_ready) begin
          r_overflow <= 1'b1;
        end else begin
          r_bit   <= w_bit;
          r_valid <= 1'b1;
        end
      end else if (w_accept) begin
        r_bit   <= 1'b0;
        r_valid <= 1'b0;
      end
    end
  end

  assign bit_if.bit_out   = r_bit;
  assign bit_if.bit_valid = r_valid;
  assign busy             = (r_state == DEMOD) || (r_state == DRAIN);
  assign frame_done       = r_frame_done;
  assign overflow         = r_overflow;

endmodule
